rr_decode_arbiter: RTL

Round-robin arbiter that shares one 8-way one-hot select resource among 8 requesters. It registers a 3-bit owner index and drives it through a 3:8 one-hot decode stage, so exactly one grant line is active at a time. It sits in front of any shared 8-slot datapath (bus, mux, memory port) and sequences ownership fairly, with an optional hold-time limit.

---
 rtl/rr_arb_pkg.sv | 32 +++
 rtl/onehot_dec3to8.sv | 12 +
 rtl/rr_decode_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and the round-robin search helper for rr_decode_arbiter.
package rr_arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Walks from the farthest offset down to ptr so the nearest set bit wins last.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [IDX_W-1:0] ptr);
        pick_t            r;
        logic [IDX_W-1:0] k;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = ptr + IDX_W'(i);
            if (req[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_dec3to8.sv
// Combinational 3:8 one-hot decoder with enable; output is all zeros when disabled.
module onehot_dec3to8
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [NREQ-1:0]  onehot
);

    assign onehot = en ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter over 8 requesters with a registered one-hot grant.
// Optional hold-time limit enabled by defining RR_HOLD_LIMIT_EN.
module rr_decode_arbiter
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output arb_state_t       dbg_state
);

    if ((HOLD_MAX < 2) || (HOLD_MAX >= (1 << CNT_W))) begin : g_bad_hold_cfg
        $error("rr_decode_arbiter: HOLD_MAX must be 2..2^CNT_W-1");
    end

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [NREQ-1:0]  gnt_nxt;
    pick_t            pick;

`ifdef RR_HOLD_LIMIT_EN
    logic [CNT_W-1:0] hcnt, hcnt_nxt;
    logic [NREQ-1:0]  others;
    pick_t            pick_x;

    assign others = req & ~(NREQ'(1) << owner);
    assign pick_x = rr_pick(others, ptr);
`endif

    assign pick = rr_pick(req, ptr);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
`ifdef RR_HOLD_LIMIT_EN
        hcnt_nxt  = hcnt;
`endif
        if (!en) begin
            // Disable drops ownership but keeps ptr so fairness survives.
            state_nxt = IDLE;
`ifdef RR_HOLD_LIMIT_EN
            hcnt_nxt  = '0;
`endif
        end else if ((state == IDLE) || !req[owner]) begin
            if (pick.found) begin
                state_nxt = OWN;
                owner_nxt = pick.idx;
                ptr_nxt   = pick.idx + IDX_W'(1);
`ifdef RR_HOLD_LIMIT_EN
                hcnt_nxt  = '0;
`endif
            end else begin
                state_nxt = IDLE;
            end
        end else begin
`ifdef RR_HOLD_LIMIT_EN
            if (hcnt == CNT_W'(HOLD_MAX - 1)) begin
                // Owner excluded from the forced search; a sole requester just restarts its window.
                if (pick_x.found) begin
                    owner_nxt = pick_x.idx;
                    ptr_nxt   = pick_x.idx + IDX_W'(1);
                end
                hcnt_nxt = '0;
            end else begin
                hcnt_nxt = hcnt + CNT_W'(1);
            end
`endif
        end
    end

    // Decode the next owner so the registered grant lands with one-cycle latency.
    onehot_dec3to8 u_dec (
        .idx    (owner_nxt),
        .en     (state_nxt == OWN),
        .onehot (gnt_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            gnt   <= '0;
`ifdef RR_HOLD_LIMIT_EN
            hcnt  <= '0;
`endif
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
`ifdef RR_HOLD_LIMIT_EN
            hcnt  <= hcnt_nxt;
`endif
        end
    end

    assign gnt_vld   = (state == OWN);
    assign gnt_idx   = owner;
    assign dbg_state = state;

endmodule
